// File: rtl/reglk_bank_ctrl_pkg.sv
// Register-lock bank: shared types and constants.
// Unlock sequencer state encoding and counter width.
package reglk_bank_ctrl_pkg;

    typedef enum logic [1:0] {
        LOCKED,
        UNLOCK_PEND,
        UNLOCKED,
        RELOCK
    } reglk_state_e;

    // Wide enough for UNLOCK_DLY and UNLOCK_TIMEOUT up to 65535
    localparam int CNT_W = 16;

endpackage

// File: rtl/reglk_bank_ctrl_if.sv
// Register-lock bank: request/response bus.
// One-cycle grant, registered response one cycle later.
interface reglk_bank_ctrl_if #(
    parameter int AW     = 3,
    parameter int WORD_W = 32
);
    logic              req;
    logic              we;
    logic [AW-1:0]     addr;
    logic [WORD_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [WORD_W-1:0] rdata;
    logic              err;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/reglk_bank_ctrl_unlock_seq.sv
// Register-lock bank: debug unlock sequencer.
// Unlock delay, window timeout and word-by-word relock sweep.
module reglk_bank_ctrl_unlock_seq
    import reglk_bank_ctrl_pkg::*;
#(
    parameter  int NUM_WORDS      = 6,
    parameter  int UNLOCK_DLY     = 16,
    parameter  int UNLOCK_TIMEOUT = 1024,
    localparam int AW             = $clog2(NUM_WORDS)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          jtag_unlock,
    input  logic          sw_relock,
    output reglk_state_e  state,
    output logic          sweep_en,
    output logic [AW-1:0] sweep_idx,
    output logic          unlocked
);

    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(UNLOCK_DLY - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(UNLOCK_TIMEOUT - 1);
    localparam logic [AW-1:0]    IDX_LAST = AW'(NUM_WORDS - 1);
    localparam bit               TMO_EN   = (UNLOCK_TIMEOUT != 0);

    reglk_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic             unl_q;
    logic             tmo_hit;

    assign tmo_hit = TMO_EN && (tcnt_q == TMO_LAST);

    // Next state and counter updates; relock strobe beats jtag
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tcnt_d  = tcnt_q;
        idx_d   = idx_q;
        unique case (state_q)
            LOCKED: begin
                cnt_d = '0;
                if (!sw_relock && jtag_unlock) begin
                    state_d = UNLOCK_PEND;
                end
            end
            UNLOCK_PEND: begin
                if (sw_relock || !jtag_unlock) begin
                    state_d = LOCKED;
                    cnt_d   = '0;
                end else if (cnt_q == DLY_LAST) begin
                    state_d = UNLOCKED;
                    cnt_d   = '0;
                    tcnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            UNLOCKED: begin
                tcnt_d = tcnt_q + CNT_W'(1);
                if (sw_relock || !jtag_unlock || tmo_hit) begin
                    state_d = RELOCK;
                    tcnt_d  = '0;
                    idx_d   = '0;
                end
            end
            RELOCK: begin
                idx_d = idx_q + AW'(1);
                if (idx_q == IDX_LAST) begin
                    state_d = LOCKED;
                    idx_d   = '0;
                end
            end
            default: state_d = LOCKED;
        endcase
    end

    // State, counters and the registered unlocked flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= LOCKED;
            cnt_q   <= '0;
            tcnt_q  <= '0;
            idx_q   <= '0;
            unl_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
            idx_q   <= idx_d;
            unl_q   <= (state_d == UNLOCKED);
        end
    end

    assign state     = state_q;
    assign sweep_en  = (state_q == RELOCK);
    assign sweep_idx = idx_q;
    assign unlocked  = unl_q;

endmodule

// File: rtl/reglk_bank_ctrl.sv
// Register-lock bank: lock array, access port and error logic.
// Lock bits are set-only outside the debug unlock window.
module reglk_bank_ctrl
    import reglk_bank_ctrl_pkg::*;
#(
    parameter  int NUM_WORDS      = 6,
    parameter  int WORD_W         = 32,
    parameter  int UNLOCK_DLY     = 16,
    parameter  int UNLOCK_TIMEOUT = 1024,
    localparam int AW             = $clog2(NUM_WORDS)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        jtag_unlock_i,
    input  logic                        sw_relock_i,
    reglk_bank_ctrl_if.slave            bus,
    output logic [NUM_WORDS*WORD_W-1:0] reglk_o,
    output logic                        unlocked_o
);

    localparam logic [AW:0] NW_LIM = (AW + 1)'(NUM_WORDS);

    reglk_state_e state;
    logic         sweep_en;
    logic [AW-1:0] sweep_idx;

    logic [NUM_WORDS-1:0][WORD_W-1:0] lk_q;

    logic              gnt;
    logic              addr_ok;
    logic              is_unl;
    logic [AW-1:0]     a;
    logic [WORD_W-1:0] cur;
    logic [WORD_W-1:0] wr_val;
    logic              wr_en;
    logic [WORD_W-1:0] rdata_d;
    logic              err_d;

    logic              rvalid_q;
    logic [WORD_W-1:0] rdata_q;
    logic              err_q;

    reglk_bank_ctrl_unlock_seq #(
        .NUM_WORDS      (NUM_WORDS),
        .UNLOCK_DLY     (UNLOCK_DLY),
        .UNLOCK_TIMEOUT (UNLOCK_TIMEOUT)
    ) u_seq (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .jtag_unlock (jtag_unlock_i),
        .sw_relock   (sw_relock_i),
        .state       (state),
        .sweep_en    (sweep_en),
        .sweep_idx   (sweep_idx),
        .unlocked    (unlocked_o)
    );

    // Grant, address check, write value and response decode
    always_comb begin
        gnt     = bus.req && (state != RELOCK);
        addr_ok = ({1'b0, bus.addr} < NW_LIM);
        a       = addr_ok ? bus.addr : '0;
        cur     = lk_q[a];
        is_unl  = (state == UNLOCKED);
        wr_val  = is_unl ? bus.wdata : (cur | bus.wdata);
        wr_en   = gnt && bus.we && addr_ok;
        rdata_d = (gnt && !bus.we && addr_ok) ? cur : '0;
        err_d   = gnt && (!addr_ok ||
                  (bus.we && !is_unl && (|(cur & ~bus.wdata))));
    end

    // Lock array: sweep has priority, no grants happen during it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lk_q <= '1;
        end else if (sweep_en) begin
            lk_q[sweep_idx] <= '1;
        end else if (wr_en) begin
            lk_q[a] <= wr_val;
        end
    end

    // Registered response, one cycle after grant
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= gnt;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign bus.gnt    = gnt;
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = rdata_q;
    assign bus.err    = err_q;
    assign reglk_o    = lk_q;

endmodule

// File: tb/tb_reglk_bank_ctrl.sv
// Register-lock bank bench: directed stimulus with a response scoreboard.
// Built with UNLOCK_DLY=16 and UNLOCK_TIMEOUT=8.
module tb_reglk_bank_ctrl;

    localparam int NW = 6;
    localparam int WW = 32;
    localparam int AW = 3;
    localparam logic [NW*WW-1:0] ALL1 = '1;

    typedef struct {
        logic [WW-1:0] rd;
        logic          er;
        string         tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic jtag = 1'b0;
    logic relock = 1'b0;
    logic [NW*WW-1:0] reglk;
    logic unl;
    logic seen;
    logic [NW-1:0][WW-1:0] ev;

    int total = 0;
    int bad = 0;
    exp_t sb[$];
    exp_t m;

    reglk_bank_ctrl_if #(.AW(AW), .WORD_W(WW)) bus ();

    reglk_bank_ctrl #(
        .NUM_WORDS      (NW),
        .WORD_W         (WW),
        .UNLOCK_DLY     (16),
        .UNLOCK_TIMEOUT (8)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .jtag_unlock_i (jtag),
        .sw_relock_i   (relock),
        .bus           (bus),
        .reglk_o       (reglk),
        .unlocked_o    (unl)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [WW-1:0] act,
                         input logic [WW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [NW*WW-1:0] act,
                        input logic [NW*WW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One granted access; the expected response goes to the scoreboard
    task automatic access(input logic w, input logic [AW-1:0] a,
                          input logic [WW-1:0] d, input logic [WW-1:0] er,
                          input logic ee, input string tag);
        exp_t e;
        bus.req = 1'b1;
        bus.we = w;
        bus.addr = a;
        bus.wdata = d;
        @(negedge clk);
        chk1({tag, " gnt"}, bus.gnt, 1'b1);
        if (bus.gnt) begin
            e.rd = er;
            e.er = ee;
            e.tag = tag;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        bus.we = 1'b0;
        bus.addr = '0;
        bus.wdata = '0;
    endtask

    // LOCKED->PEND edge plus 16 counting edges; one edge short stays locked
    task automatic unlock(input string tag);
        jtag = 1'b1;
        tick(16);
        chk1({tag, " pre-unlock"}, unl, 1'b0);
        tick(1);
        chk1({tag, " unlocked"}, unl, 1'b1);
    endtask

    // Monitor: every response is matched against the oldest expectation
    always @(negedge clk) begin
        if (rst_ni && bus.rvalid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rsp_unexpected: rvalid got 1 want 0");
            end else begin
                m = sb.pop_front();
                chk32({m.tag, " rdata"}, bus.rdata, m.rd);
                chk1({m.tag, " err"}, bus.err, m.er);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        bus.req = 1'b0;
        bus.we = 1'b0;
        bus.addr = '0;
        bus.wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chkw("rst reglk", reglk, ALL1);
        chk1("rst unl", unl, 1'b0);
        chk1("rst rvalid", bus.rvalid, 1'b0);
        chk32("rst rdata", bus.rdata, 32'h0);
        chk1("rst err", bus.err, 1'b0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        tick(1);

        // T1
        chkw("T1 reglk", reglk, ALL1);
        chk1("T1 unl", unl, 1'b0);
        access(1'b0, 3'd5, 32'h0, 32'hFFFFFFFF, 1'b0, "T1 rd5");

        // T2 locked writes and T6 out-of-range, back to back
        access(1'b1, 3'd2, 32'h0000FFFF, 32'h0, 1'b1, "T2 wr2 clr");
        access(1'b0, 3'd2, 32'h0, 32'hFFFFFFFF, 1'b0, "T2 rd2");
        access(1'b1, 3'd3, 32'hFFFFFFFF, 32'h0, 1'b0, "T2 wr3 ones");
        access(1'b1, 3'd1, 32'h0, 32'h0, 1'b1, "T2 wr1 zero");
        access(1'b0, 3'd7, 32'h0, 32'h0, 1'b1, "T6 rd7");
        access(1'b1, 3'd6, 32'h0, 32'h0, 1'b1, "T6 wr6");
        tick(1);
        chkw("T2 reglk kept", reglk, ALL1);

        // T3 jtag dropped one edge early
        seen = 1'b0;
        jtag = 1'b1;
        repeat (16) begin
            tick(1);
            seen = seen | unl;
        end
        jtag = 1'b0;
        repeat (4) begin
            tick(1);
            seen = seen | unl;
        end
        chk1("T3 short hold", seen, 1'b0);

        // T3/T5 window with timeout
        unlock("T3");
        access(1'b1, 3'd2, 32'h0, 32'h0, 1'b0, "T2 unl wr0");
        access(1'b1, 3'd2, 32'h1, 32'h0, 1'b0, "T2 unl wr1");
        access(1'b0, 3'd2, 32'h0, 32'h1, 1'b0, "T2 unl rd2");
        access(1'b1, 3'd0, 32'h0000FFFF, 32'h0, 1'b0, "T5 wr0");
        access(1'b0, 3'd0, 32'h0, 32'h0000FFFF, 1'b0, "T5 rd0");
        tick(2);
        chk1("T5 unl cycle 8", unl, 1'b1);
        tick(1);
        chk1("T5 timeout", unl, 1'b0);
        chk32("T5 w2 pre-sweep", reglk[2*WW +: WW], 32'h1);
        jtag = 1'b0;
        tick(6);
        chkw("T5 swept", reglk, ALL1);

        // T5 relock beats jtag in the same cycle: unlock one edge later
        jtag = 1'b1;
        relock = 1'b1;
        tick(1);
        relock = 1'b0;
        tick(16);
        chk1("T5 relock wins", unl, 1'b0);
        tick(1);
        chk1("T5 late unlock", unl, 1'b1);
        relock = 1'b1;
        tick(1);
        relock = 1'b0;
        chk1("T5 sw relock", unl, 1'b0);
        bus.req = 1'b1;
        bus.we = 1'b0;
        bus.addr = '0;
        @(negedge clk);
        chk1("T5 relock gnt", bus.gnt, 1'b0);
        bus.req = 1'b0;
        jtag = 1'b0;
        tick(6);
        chkw("T5 relock swept", reglk, ALL1);

        // T4 clear all words, last write lands as jtag drops
        unlock("T4");
        for (int i = 0; i < 5; i++) begin
            access(1'b1, AW'(i), 32'h0, 32'h0, 1'b0, "T4 clr");
        end
        jtag = 1'b0;
        access(1'b1, 3'd5, 32'h12345678, 32'h0, 1'b0, "T4 last wr");
        bus.req = 1'b1;
        bus.we = 1'b0;
        bus.addr = '0;
        ev = '0;
        ev[5] = 32'h12345678;
        for (int k = 0; k < NW; k++) begin
            @(negedge clk);
            chk1("T4 gnt blocked", bus.gnt, 1'b0);
            chkw("T4 sweep order", reglk, ev);
            ev[k] = '1;
            @(posedge clk);
            #1;
        end
        bus.req = 1'b0;
        chkw("T4 all ones", reglk, ALL1);
        chk1("T4 unl", unl, 1'b0);
        access(1'b0, 3'd5, 32'h0, 32'hFFFFFFFF, 1'b0, "T4 rd5");

        // T6 async reset in the middle of a sweep
        unlock("T6");
        access(1'b1, 3'd1, 32'h0, 32'h0, 1'b0, "T6 clr1");
        access(1'b1, 3'd4, 32'h0, 32'h0, 1'b0, "T6 clr4");
        jtag = 1'b0;
        tick(3);
        ev = '1;
        ev[4] = '0;
        chkw("T6 mid sweep", reglk, ev);
        rst_ni = 1'b0;
        #1;
        chkw("T6 rst ones", reglk, ALL1);
        chk1("T6 rst unl", unl, 1'b0);
        tick(1);
        rst_ni = 1'b1;
        tick(1);
        access(1'b0, 3'd4, 32'h0, 32'hFFFFFFFF, 1'b0, "T6 rd4");

        tick(2);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
